// File: rtl/me_sad_engine.sv
// me_sad_engine: block-matching SAD engine for motion estimation.
// Loads a BLK_W x BLK_H current block one row per handshake, then streams
// NUM_CAND candidate blocks row by row and reports the candidate with the
// smallest sum of absolute differences (lowest index wins ties).
// Pipeline: per-lane |cur-ref| register -> row-sum register -> accumulate/compare.
// Optional feature: define ME_EARLY_TERM_EN to stop accumulating a candidate
// once its partial SAD can no longer beat the current best (counted in skip_cnt).
module me_sad_engine #(
    parameter int PIX_WIDTH = 8,
    parameter int BLK_W     = 4,
    parameter int BLK_H     = 4,
    parameter int NUM_CAND  = 16,
    localparam int SAD_W    = PIX_WIDTH + $clog2(BLK_W * BLK_H),
    localparam int IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cur_valid,
    output logic                       cur_ready,
    input  logic [BLK_W*PIX_WIDTH-1:0] cur_row,
    input  logic                       ref_valid,
    output logic                       ref_ready,
    input  logic [BLK_W*PIX_WIDTH-1:0] ref_row,
    output logic                       busy,
    output logic                       done,
    output logic [SAD_W-1:0]           best_sad,
    output logic [IDX_W-1:0]           best_idx,
    output logic [IDX_W:0]             skip_cnt
);

`ifdef ME_EARLY_TERM_EN
    localparam bit ET_EN = 1'b1;
`else
    localparam bit ET_EN = 1'b0;
`endif

    localparam int ROW_W  = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int ROWV_W = BLK_W * PIX_WIDTH;
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(BLK_H - 1);
    localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NUM_CAND - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CUR,
        S_SEARCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ROWV_W-1:0] cur_mem [BLK_H];
    logic [ROWV_W-1:0] cur_sel;
    logic [ROWV_W-1:0] lane_diff;

    logic [ROW_W-1:0]  cur_cnt_q;
    logic [ROW_W-1:0]  ref_cnt_q;
    logic [IDX_W-1:0]  cand_q;

    // lane-difference stage
    logic              p0_valid_q, p0_last_q, p0_final_q;
    logic [IDX_W-1:0]  p0_cand_q;
    logic [ROWV_W-1:0] diff_q;

    // row-sum stage
    logic              s1_valid_q, s1_last_q, s1_final_q;
    logic [IDX_W-1:0]  s1_cand_q;
    logic [SAD_W-1:0]  s1_sum_q;
    logic [SAD_W-1:0]  row_sum;

    // accumulate / compare stage
    logic [SAD_W-1:0]  acc_q;
    logic [SAD_W-1:0]  acc_sum;
    logic [SAD_W-1:0]  best_sad_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic              best_valid_q;
    logic              term_q;
    logic [IDX_W:0]    skip_q;
    logic              fin_q;
    logic              better;

    logic start_acc, cur_acc, ref_acc;
    logic cur_last_row, ref_last_row, last_cand;

    assign start_acc    = start && (state_q == S_IDLE);
    assign cur_acc      = cur_valid && cur_ready;
    assign ref_acc      = ref_valid && ref_ready;
    assign cur_last_row = (cur_cnt_q == ROW_LAST);
    assign ref_last_row = (ref_cnt_q == ROW_LAST);
    assign last_cand    = (cand_q == CAND_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        cur_ready = 1'b0;
        ref_ready = 1'b0;
        case (state_q)
            S_IDLE:     if (start) state_d = S_LOAD_CUR;
            S_LOAD_CUR: begin
                cur_ready = 1'b1;
                if (cur_acc && cur_last_row) state_d = S_SEARCH;
            end
            S_SEARCH: begin
                ref_ready = 1'b1;
                if (ref_acc && ref_last_row && last_cand) state_d = S_DRAIN;
            end
            S_DRAIN:    if (fin_q) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Current-block row storage, read by the row index of the incoming ref row
    always_ff @(posedge clk) begin
        if (cur_acc) cur_mem[cur_cnt_q] <= cur_row;
    end

    assign cur_sel = cur_mem[ref_cnt_q];

    // One absolute-difference PE per lane
    for (genvar gi = 0; gi < BLK_W; gi++) begin : g_lane
        logic [PIX_WIDTH-1:0] c_pix, r_pix;
        assign c_pix = cur_sel[gi*PIX_WIDTH +: PIX_WIDTH];
        assign r_pix = ref_row[gi*PIX_WIDTH +: PIX_WIDTH];
        assign lane_diff[gi*PIX_WIDTH +: PIX_WIDTH] =
            (c_pix >= r_pix) ? (c_pix - r_pix) : (r_pix - c_pix);
    end

    // Sum of the registered lane differences
    always_comb begin
        row_sum = '0;
        for (int i = 0; i < BLK_W; i++) begin
            row_sum = row_sum + SAD_W'(diff_q[i*PIX_WIDTH +: PIX_WIDTH]);
        end
    end

    assign acc_sum = acc_q + s1_sum_q;
    assign better  = !best_valid_q || (acc_sum < best_sad_q);

    // Counters, pipeline registers, accumulation and best tracking.
    // Rows reach the compare stage strictly in order, so best_sad_q already
    // holds the previous candidate's result when the next candidate's first
    // row is accumulated; no extra forwarding path is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_cnt_q    <= '0;
            ref_cnt_q    <= '0;
            cand_q       <= '0;
            p0_valid_q   <= 1'b0;
            p0_last_q    <= 1'b0;
            p0_final_q   <= 1'b0;
            p0_cand_q    <= '0;
            diff_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_final_q   <= 1'b0;
            s1_cand_q    <= '0;
            s1_sum_q     <= '0;
            acc_q        <= '0;
            best_sad_q   <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
            term_q       <= 1'b0;
            skip_q       <= '0;
            fin_q        <= 1'b0;
        end else begin
            if (cur_acc) cur_cnt_q <= cur_last_row ? '0 : cur_cnt_q + 1'b1;

            if (ref_acc) begin
                if (ref_last_row) begin
                    ref_cnt_q <= '0;
                    cand_q    <= cand_q + 1'b1;
                end else begin
                    ref_cnt_q <= ref_cnt_q + 1'b1;
                end
                diff_q     <= lane_diff;
                p0_last_q  <= ref_last_row;
                p0_final_q <= ref_last_row && last_cand;
                p0_cand_q  <= cand_q;
            end
            p0_valid_q <= ref_acc;

            s1_valid_q <= p0_valid_q;
            if (p0_valid_q) begin
                s1_sum_q   <= row_sum;
                s1_last_q  <= p0_last_q;
                s1_final_q <= p0_final_q;
                s1_cand_q  <= p0_cand_q;
            end

            if (s1_valid_q) begin
                if (s1_last_q) begin
                    acc_q  <= '0;
                    term_q <= 1'b0;
                    if (!(ET_EN && term_q) && better) begin
                        best_sad_q   <= acc_sum;
                        best_idx_q   <= s1_cand_q;
                        best_valid_q <= 1'b1;
                    end
                    if (s1_final_q) fin_q <= 1'b1;
                end else if (!(ET_EN && term_q)) begin
                    acc_q <= acc_sum;
                    if (ET_EN && best_valid_q && (acc_sum >= best_sad_q)) begin
                        term_q <= 1'b1;
                        skip_q <= skip_q + 1'b1;
                    end
                end
            end

            // A new search clears results and all search bookkeeping
            if (start_acc) begin
                cur_cnt_q    <= '0;
                ref_cnt_q    <= '0;
                cand_q       <= '0;
                p0_valid_q   <= 1'b0;
                s1_valid_q   <= 1'b0;
                acc_q        <= '0;
                best_sad_q   <= '0;
                best_idx_q   <= '0;
                best_valid_q <= 1'b0;
                term_q       <= 1'b0;
                skip_q       <= '0;
                fin_q        <= 1'b0;
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign best_sad = best_sad_q;
    assign best_idx = best_idx_q;
    assign skip_cnt = ET_EN ? skip_q : '0;

endmodule

// File: tb/tb_me_sad_engine.sv
// Scoreboard bench for me_sad_engine (BLK 4x4, 4 candidates, 8-bit pixels).
// Expected results are pushed when a search is issued; a negedge monitor pops
// and compares whenever done is seen, including done latency after the last
// accepted reference row.
module tb_me_sad_engine;
    localparam int P  = 8;
    localparam int BW = 4;
    localparam int BH = 4;
    localparam int NC = 4;

`ifdef ME_EARLY_TERM_EN
    localparam int ET = 1;
`else
    localparam int ET = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start;
    logic        cur_valid, cur_ready, ref_valid, ref_ready;
    logic [31:0] cur_row, ref_row;
    logic        busy, done;
    logic [11:0] best_sad;
    logic [1:0]  best_idx;
    logic [2:0]  skip_cnt;

    me_sad_engine #(
        .PIX_WIDTH(P), .BLK_W(BW), .BLK_H(BH), .NUM_CAND(NC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_row(cur_row),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_row(ref_row),
        .busy(busy), .done(done),
        .best_sad(best_sad), .best_idx(best_idx), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sad;
        int idx;
        int skip;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   hs_cyc   = 0;
    int   done_cnt = 0;
    bit   done_prev = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: one line per completed search
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check("done_width", int'(done_prev), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                $display("done: best_sad=%0d best_idx=%0d skip_cnt=%0d latency=%0d",
                         best_sad, best_idx, skip_cnt, cyc - hs_cyc);
                check("best_sad", int'(best_sad), e.sad);
                check("best_idx", int'(best_idx), e.idx);
                check("skip_cnt", int'(skip_cnt), e.skip);
                check("done_latency", cyc - hs_cyc, 3);
            end
            done_cnt++;
        end
        done_prev = done;
    end

    task automatic do_start(input bit pre);
        if (!pre) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("clear_on_start", int'(best_sad), 0);
    endtask

    task automatic send_row(input bit is_ref, input logic [7:0] v, input bit gap);
        int tries;
        @(negedge clk);
        if (gap) begin
            ref_valid = 1'b0;
            cur_valid = 1'b0;
            @(negedge clk);
        end
        if (is_ref) begin
            cur_valid = 1'b0;
            ref_valid = 1'b1;
            ref_row   = {4{v}};
        end else begin
            ref_valid = 1'b0;
            cur_valid = 1'b1;
            cur_row   = {4{v}};
        end
        tries = 0;
        while (!(is_ref ? ref_ready : cur_ready) && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 50) begin
            check("handshake_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            if (is_ref) hs_cyc = cyc;
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d done pulses, expected %0d", tag, done_cnt, target);
        end
    endtask

    task automatic run_search(input logic [7:0] cv,
                              input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3,
                              input bit gap, input bit pulse, input bit pre,
                              input int esad, input int eidx, input int eskip,
                              input string tag);
        logic [7:0] cands [4];
        exp_t e;
        int   target;
        cands[0] = c0; cands[1] = c1; cands[2] = c2; cands[3] = c3;
        e.sad = esad; e.idx = eidx; e.skip = eskip;
        exp_q.push_back(e);
        target = done_cnt + 1;
        do_start(pre);
        for (int r = 0; r < BH; r++) send_row(1'b0, cv, 1'b0);
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < BH; r++) begin
                send_row(1'b1, cands[c], gap);
                if (pulse && c == 1 && r == BH - 1) begin
                    @(negedge clk);
                    ref_valid = 1'b0;
                    start     = 1'b1;
                    @(negedge clk);
                    start     = 1'b0;
                end
            end
        end
        @(negedge clk);
        ref_valid = 1'b0;
        cur_valid = 1'b0;
        wait_done(target, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        cur_valid = 1'b0; ref_valid = 1'b0;
        cur_row = '0; ref_row = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cur_ready", int'(cur_ready), 0);
        check("rst_ref_ready", int'(ref_ready), 0);
        check("rst_best_sad", int'(best_sad), 0);
        check("rst_best_idx", int'(best_idx), 0);
        check("rst_skip_cnt", int'(skip_cnt), 0);
        rst = 1'b0;

        // SADs 32,0,16,0: tie at 0 keeps candidate 1
        run_search(8'd10, 8'd12, 8'd10, 8'd9, 8'd10, 1'b0, 1'b0, 1'b0, 0, 1, ET ? 2 : 0, "basic");
        // Maximum SAD 16*255 = 4080 without wrap
        run_search(8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 4080, 0, 0, "max");
        repeat (4) @(negedge clk);
        check("hold_best_sad", int'(best_sad), 4080);
        check("hold_busy", int'(busy), 0);
        // Same as basic with a bubble before every ref row
        run_search(8'd10, 8'd12, 8'd10, 8'd9, 8'd10, 1'b1, 1'b0, 1'b0, 0, 1, ET ? 2 : 0, "stall");
        // SADs 128,32,32,48: tie keeps candidate 1
        run_search(8'd42, 8'd50, 8'd40, 8'd40, 8'd45, 1'b0, 1'b0, 1'b0, 32, 1, ET ? 1 : 0, "tie");
        // Candidate 0 perfect, others far away
        run_search(8'd10, 8'd10, 8'd60, 8'd60, 8'd60, 1'b0, 1'b0, 1'b0, 0, 0, ET ? 3 : 0, "early");
        // Start pulse during SEARCH is ignored
        run_search(8'd10, 8'd12, 8'd10, 8'd9, 8'd10, 1'b0, 1'b1, 1'b0, 0, 1, ET ? 2 : 0, "pulse");

        // Reset in the middle of SEARCH: no result for the aborted search
        do_start(1'b0);
        for (int r = 0; r < BH; r++) send_row(1'b0, 8'd10, 1'b0);
        for (int r = 0; r < 6; r++) send_row(1'b1, 8'd20, 1'b0);
        @(negedge clk);
        ref_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_ref_ready", int'(ref_ready), 0);
        check("midrst_best_sad", int'(best_sad), 0);
        check("midrst_best_idx", int'(best_idx), 0);
        check("midrst_skip_cnt", int'(skip_cnt), 0);
        start = 1'b1;
        run_search(8'd10, 8'd12, 8'd10, 8'd9, 8'd10, 1'b0, 1'b0, 1'b1, 0, 1, ET ? 2 : 0, "after_rst");

        repeat (10) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
